// File: rtl/wb_regfile.sv
// Writeback-stage register file: one-entry MEM/WB latch, commit one edge later,
// two read ports and three special-register taps, all bypassed from the latch.
module wb_regfile #(
    parameter int                 DATA_W  = 16,
    parameter logic [DATA_W-1:0]  SP_INIT = 16'hBF00
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              mem_reg_write,
    input  logic [3:0]        mem_write_reg,
    input  logic [DATA_W-1:0] mem_data,
    input  logic              stall,
    input  logic              flush,
    input  logic [3:0]        rd_x_idx,
    input  logic [3:0]        rd_y_idx,
    output logic [DATA_W-1:0] rd_x_data,
    output logic [DATA_W-1:0] rd_y_data,
    output logic [DATA_W-1:0] sp_data,
    output logic [DATA_W-1:0] in_data,
    output logic [DATA_W-1:0] t_data,
    output logic              wb_busy
);
    localparam logic [3:0] IDX_IN    = 4'h9;
    localparam logic [3:0] IDX_SP    = 4'hA;
    localparam logic [3:0] IDX_T     = 4'hB;
    localparam logic [3:0] IDX_EMPTY = 4'hF;

    function automatic logic is_mapped(input logic [3:0] idx);
        return (idx[3] == 1'b0) || (idx == IDX_IN) || (idx == IDX_SP) || (idx == IDX_T);
    endfunction

    logic [DATA_W-1:0] gpr [8];
    logic [DATA_W-1:0] in_q;
    logic [DATA_W-1:0] sp_q;
    logic [DATA_W-1:0] t_q;

    logic              wb_valid;
    logic [3:0]        wb_reg;
    logic [DATA_W-1:0] wb_data;

    logic [DATA_W-1:0] view [16];

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < 8; i++) begin
                gpr[i] <= '0;
            end
            in_q     <= '0;
            sp_q     <= SP_INIT;
            t_q      <= '0;
            wb_valid <= 1'b0;
            wb_reg   <= IDX_EMPTY;
            wb_data  <= '0;
        end else begin
            // A flushed entry must never reach storage, even when not stalled.
            if (wb_valid && !stall && !flush) begin
                if (!wb_reg[3]) begin
                    gpr[wb_reg[2:0]] <= wb_data;
                end else begin
                    case (wb_reg)
                        IDX_IN:  in_q <= wb_data;
                        IDX_SP:  sp_q <= wb_data;
                        IDX_T:   t_q  <= wb_data;
                        default: ;
                    endcase
                end
            end

            if (flush) begin
                wb_valid <= 1'b0;
            end else if (!stall) begin
                wb_valid <= mem_reg_write && is_mapped(mem_write_reg);
                wb_reg   <= mem_write_reg;
                wb_data  <= mem_data;
            end
        end
    end

    // Architectural view of all 16 indices; unmapped slots read as zero and
    // wb_valid is only ever set for mapped indices, so the bypass is safe.
    always_comb begin
        for (int i = 0; i < 16; i++) begin
            view[i] = '0;
        end
        for (int i = 0; i < 8; i++) begin
            view[i] = gpr[i];
        end
        view[IDX_IN] = in_q;
        view[IDX_SP] = sp_q;
        view[IDX_T]  = t_q;
        if (wb_valid) begin
            view[wb_reg] = wb_data;
        end
    end

    assign rd_x_data = view[rd_x_idx];
    assign rd_y_data = view[rd_y_idx];
    assign sp_data   = view[IDX_SP];
    assign in_data   = view[IDX_IN];
    assign t_data    = view[IDX_T];
    assign wb_busy   = wb_valid;

endmodule

// File: tb/tb_wb_regfile.sv
// Self-checking bench for wb_regfile: directed scenarios plus randomized traffic
// checked against an architectural model (register array + pending-write entry).
module tb_wb_regfile;
    logic        clk;
    logic        rst;
    logic        mem_reg_write;
    logic [3:0]  mem_write_reg;
    logic [15:0] mem_data;
    logic        stall;
    logic        flush;
    logic [3:0]  rd_x_idx;
    logic [3:0]  rd_y_idx;
    logic [15:0] rd_x_data;
    logic [15:0] rd_y_data;
    logic [15:0] sp_data;
    logic [15:0] in_data;
    logic [15:0] t_data;
    logic        wb_busy;

    int errors = 0;
    int checks = 0;

    wb_regfile #(.DATA_W(16), .SP_INIT(16'hBF00)) dut (
        .clk           (clk),
        .rst           (rst),
        .mem_reg_write (mem_reg_write),
        .mem_write_reg (mem_write_reg),
        .mem_data      (mem_data),
        .stall         (stall),
        .flush         (flush),
        .rd_x_idx      (rd_x_idx),
        .rd_y_idx      (rd_y_idx),
        .rd_x_data     (rd_x_data),
        .rd_y_data     (rd_y_data),
        .sp_data       (sp_data),
        .in_data       (in_data),
        .t_data        (t_data),
        .wb_busy       (wb_busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference: architectural contents plus the one pending write.
    logic [15:0] m_reg [16];
    logic        m_pv;
    logic [3:0]  m_preg;
    logic [15:0] m_pdata;

    function automatic logic m_mapped(input logic [3:0] idx);
        return (idx <= 4'd7) || (idx == 4'h9) || (idx == 4'hA) || (idx == 4'hB);
    endfunction

    function automatic logic [15:0] m_read(input logic [3:0] idx);
        if (!m_mapped(idx)) return 16'h0000;
        if (m_pv && m_preg == idx) return m_pdata;
        return m_reg[idx];
    endfunction

    task automatic m_reset();
        for (int i = 0; i < 16; i++) m_reg[i] = 16'h0000;
        m_reg[4'hA] = 16'hBF00;
        m_pv = 1'b0;
        m_preg = 4'hF;
        m_pdata = 16'h0000;
    endtask

    task automatic chk(input string tag, input logic [15:0] got, input logic [15:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic check_all();
        logic [3:0] save_x;
        logic [3:0] probe;
        chk("rd_x", rd_x_data, m_read(rd_x_idx));
        chk("rd_y", rd_y_data, m_read(rd_y_idx));
        chk("sp", sp_data, m_read(4'hA));
        chk("in", in_data, m_read(4'h9));
        chk("t", t_data, m_read(4'hB));
        chk("busy", {15'd0, wb_busy}, {15'd0, m_pv});
        // The read path must follow an index change within the cycle.
        save_x = rd_x_idx;
        probe = 4'($urandom_range(0, 15));
        rd_x_idx = probe;
        #1;
        chk("rd_x_comb", rd_x_data, m_read(probe));
        rd_x_idx = save_x;
        #1;
    endtask

    // Drive one cycle of inputs, let the edge happen, update the model, check.
    task automatic cycle(input logic we, input logic [3:0] widx, input logic [15:0] wdata,
                         input logic st, input logic fl,
                         input logic [3:0] rx, input logic [3:0] ry);
        mem_reg_write = we;
        mem_write_reg = widx;
        mem_data = wdata;
        stall = st;
        flush = fl;
        rd_x_idx = rx;
        rd_y_idx = ry;
        @(posedge clk);
        if (m_pv && !st && !fl) m_reg[m_preg] = m_pdata;
        if (fl) begin
            m_pv = 1'b0;
        end else if (!st) begin
            m_pv = we && m_mapped(widx);
            m_preg = widx;
            m_pdata = wdata;
        end
        @(negedge clk);
        check_all();
    endtask

    initial begin
        rst = 1'b0;
        mem_reg_write = 1'b0;
        mem_write_reg = 4'h0;
        mem_data = 16'h0;
        stall = 1'b0;
        flush = 1'b0;
        rd_x_idx = 4'hA;
        rd_y_idx = 4'h3;
        m_reset();
        repeat (2) @(negedge clk);
        check_all();
        chk("rst_sp_x", rd_x_data, 16'hBF00);
        chk("rst_r3_y", rd_y_data, 16'h0000);
        chk("rst_busy", {15'd0, wb_busy}, 16'h0000);
        rst = 1'b1;

        cycle(1'b1, 4'h3, 16'h1234, 1'b0, 1'b0, 4'h3, 4'h0);
        chk("r3_bypass", rd_x_data, 16'h1234);
        cycle(1'b0, 4'h0, 16'h0000, 1'b0, 1'b0, 4'h3, 4'h0);
        chk("r3_stored", rd_x_data, 16'h1234);

        cycle(1'b1, 4'hF, 16'hFFFF, 1'b0, 1'b0, 4'h3, 4'hF);
        chk("empty_busy", {15'd0, wb_busy}, 16'h0000);
        cycle(1'b1, 4'hC, 16'hFFFF, 1'b0, 1'b0, 4'hC, 4'h3);
        chk("unmapped_busy", {15'd0, wb_busy}, 16'h0000);
        chk("unmapped_read", rd_x_data, 16'h0000);
        chk("unmapped_r3", rd_y_data, 16'h1234);

        cycle(1'b1, 4'hB, 16'h0001, 1'b0, 1'b0, 4'hB, 4'h1);
        for (int i = 0; i < 3; i++) begin
            cycle(1'b1, 4'h1, 16'h5555, 1'b1, 1'b0, 4'hB, 4'h1);
            chk("stall_t", t_data, 16'h0001);
            chk("stall_r1", rd_y_data, 16'h0000);
        end
        cycle(1'b1, 4'h1, 16'h5555, 1'b0, 1'b0, 4'hB, 4'h1);
        chk("unstall_r1", rd_y_data, 16'h5555);
        cycle(1'b0, 4'h0, 16'h0000, 1'b0, 1'b0, 4'hB, 4'h1);
        chk("t_stored", t_data, 16'h0001);
        chk("r1_stored", rd_y_data, 16'h5555);

        cycle(1'b1, 4'hA, 16'h00AA, 1'b0, 1'b0, 4'hA, 4'h0);
        chk("sp_bypass", sp_data, 16'h00AA);
        cycle(1'b0, 4'h0, 16'h0000, 1'b0, 1'b1, 4'hA, 4'h0);
        chk("flush_busy", {15'd0, wb_busy}, 16'h0000);
        chk("flush_sp", sp_data, 16'hBF00);
        cycle(1'b1, 4'hA, 16'h00AA, 1'b0, 1'b0, 4'hA, 4'h0);
        cycle(1'b0, 4'h0, 16'h0000, 1'b1, 1'b1, 4'hA, 4'h0);
        chk("stflush_busy", {15'd0, wb_busy}, 16'h0000);
        chk("stflush_sp", sp_data, 16'hBF00);
        cycle(1'b0, 4'h0, 16'h0000, 1'b0, 1'b0, 4'hA, 4'h0);
        chk("stflush_sp2", sp_data, 16'hBF00);

        cycle(1'b1, 4'h2, 16'hAAAA, 1'b0, 1'b0, 4'h2, 4'h7);
        cycle(1'b1, 4'h2, 16'hBBBB, 1'b0, 1'b0, 4'h2, 4'h7);
        chk("b2b_second", rd_x_data, 16'hBBBB);

        cycle(1'b1, 4'h7, 16'h7777, 1'b0, 1'b0, 4'h7, 4'h2);
        chk("r7_pending", rd_x_data, 16'h7777);
        #2;
        mem_reg_write = 1'b0;
        rst = 1'b0;
        m_reset();
        #1;
        check_all();
        @(posedge clk);
        @(negedge clk);
        rst = 1'b1;
        cycle(1'b0, 4'h0, 16'h0000, 1'b0, 1'b0, 4'h7, 4'h2);
        chk("r7_after_rst", rd_x_data, 16'h0000);
        chk("busy_after_rst", {15'd0, wb_busy}, 16'h0000);
        chk("r2_after_rst", rd_y_data, 16'h0000);

        for (int i = 0; i < 400; i++) begin
            cycle(1'($urandom_range(0, 3) != 0),
                  4'($urandom_range(0, 15)),
                  16'($urandom()),
                  1'($urandom_range(0, 4) == 0),
                  1'($urandom_range(0, 7) == 0),
                  4'($urandom_range(0, 15)),
                  4'($urandom_range(0, 15)));
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
